// File: rtl/timer_pkg.sv
// Shared definitions for the timer status stage: TSR/TIER bit positions and flag update helper.
// Compare-match support is compiled in with the TIMER_STATUS_CMP_EN macro.
package timer_pkg;

    localparam int TSR_W = 3;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;
    localparam int TSR_CMP = 2;

    localparam int TIER_OVF = TSR_OVF;
    localparam int TIER_UDF = TSR_UDF;
    localparam int TIER_CMP = TSR_CMP;

`ifdef TIMER_STATUS_CMP_EN
    localparam logic [TSR_W-1:0] TSR_IMPL = 3'b111;
`else
    localparam logic [TSR_W-1:0] TSR_IMPL = 3'b011;
`endif

    // Sticky write-1-to-clear flag update; a new event wins over a same-cycle clear.
    function automatic logic [TSR_W-1:0] flag_next(
        input logic [TSR_W-1:0] evt,
        input logic [TSR_W-1:0] cur,
        input logic             wr,
        input logic [TSR_W-1:0] wdata
    );
        logic [TSR_W-1:0] clr;
        clr = wdata & {TSR_W{wr}};
        return (evt | (cur & ~clr)) & TSR_IMPL;
    endfunction

endpackage

// File: rtl/wrap_detect.sv
// Samples the counter each cycle and reports raw overflow/underflow (and compare-match
// when TIMER_STATUS_CMP_EN is defined) events for the current cycle.
module wrap_detect
    import timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             updw,
    input  logic             en,
    input  logic             load,
`ifdef TIMER_STATUS_CMP_EN
    input  logic [CNT_W-1:0] tcmp,
    output logic             cmp_evt,
`endif
    output logic             ovf_evt,
    output logic             udf_evt
);

    logic [CNT_W-1:0] prev_cnt;
    logic             prev_vld;
    logic             load_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            prev_cnt <= '0;
            prev_vld <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            prev_cnt <= cnt;
            prev_vld <= 1'b1;
            load_q   <= load;
        end
    end

    // load_q marks the cycle in which cnt shows a freshly loaded TDR value, not a count.
    logic sample_ok;
    logic prev_max;
    logic prev_zero;
    logic cur_max;
    logic cur_zero;

    always_comb begin
        sample_ok = prev_vld & ~load_q;
        prev_max  = (prev_cnt == {CNT_W{1'b1}});
        prev_zero = (prev_cnt == {CNT_W{1'b0}});
        cur_max   = (cnt == {CNT_W{1'b1}});
        cur_zero  = (cnt == {CNT_W{1'b0}});
        ovf_evt   = sample_ok & en & ~updw & prev_max & cur_zero;
        udf_evt   = sample_ok & en & updw & prev_zero & cur_max;
    end

`ifdef TIMER_STATUS_CMP_EN
    // Fires only on arrival at the compare value, not while the counter dwells on it.
    always_comb begin
        cmp_evt = sample_ok & (cnt == tcmp) & (cnt != prev_cnt);
    end
`endif

endmodule

// File: rtl/timer_status.sv
// Timer status register (sticky W1C flags) and level interrupt for the timer counter.
// Define TIMER_STATUS_CMP_EN to add the tcmp input and the compare-match flag tsr[2].
module timer_status
    import timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             updw,
    input  logic             en,
    input  logic             load,
    input  logic             tsr_wr,
    input  logic [TSR_W-1:0] tsr_wdata,
    input  logic [TSR_W-1:0] tier,
`ifdef TIMER_STATUS_CMP_EN
    input  logic [CNT_W-1:0] tcmp,
`endif
    output logic [TSR_W-1:0] tsr,
    output logic             irq
);

    logic ovf_evt;
    logic udf_evt;
    logic cmp_evt;

    wrap_detect #(
        .CNT_W(CNT_W)
    ) u_wrap_detect (
        .pclk    (pclk),
        .preset  (preset),
        .cnt     (cnt),
        .updw    (updw),
        .en      (en),
        .load    (load),
`ifdef TIMER_STATUS_CMP_EN
        .tcmp    (tcmp),
        .cmp_evt (cmp_evt),
`endif
        .ovf_evt (ovf_evt),
        .udf_evt (udf_evt)
    );

`ifndef TIMER_STATUS_CMP_EN
    assign cmp_evt = 1'b0;
`endif

    logic [TSR_W-1:0] evt;
    logic [TSR_W-1:0] tsr_q;

    always_comb begin
        evt          = '0;
        evt[TSR_OVF] = ovf_evt;
        evt[TSR_UDF] = udf_evt;
        evt[TSR_CMP] = cmp_evt;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            tsr_q <= '0;
        end else begin
            tsr_q <= flag_next(evt, tsr_q, tsr_wr, tsr_wdata);
        end
    end

    // The interrupt is built from the registered flags only, never from raw events.
    assign tsr = tsr_q;
    assign irq = |(tsr_q & tier);

endmodule

// File: tb/tb_timer_status.sv
// Bench for timer_status: directed scenarios with literal expectations, then randomized
// counter traffic checked every cycle against a sample-history model of the status flags.
module tb_timer_status;

    logic       pclk = 1'b0;
    logic       preset;
    logic [7:0] cnt;
    logic       updw;
    logic       en;
    logic       load;
    logic       tsr_wr;
    logic [2:0] tsr_wdata;
    logic [2:0] tier;
    logic [7:0] tcmp;
    logic [2:0] tsr;
    logic       irq;

    int vectors = 0;
    int errors  = 0;
    bit check_on = 1'b0;

    always #5 pclk = ~pclk;

    timer_status #(.CNT_W(8)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cnt       (cnt),
        .updw      (updw),
        .en        (en),
        .load      (load),
        .tsr_wr    (tsr_wr),
        .tsr_wdata (tsr_wdata),
        .tier      (tier),
`ifdef TIMER_STATUS_CMP_EN
        .tcmp      (tcmp),
`endif
        .tsr       (tsr),
        .irq       (irq)
    );

    // Reference model: remembers what the counter showed in earlier cycles.
    typedef struct {
        logic [7:0] c;
        logic       ld;
    } samp_t;

    samp_t      hist[$];
    logic [2:0] m_tsr = 3'b000;
`ifdef TIMER_STATUS_CMP_EN
    localparam logic [2:0] IMPL = 3'b111;
`else
    localparam logic [2:0] IMPL = 3'b011;
`endif

    always @(posedge pclk) begin : model
        logic [2:0] ev;
        samp_t      p;
        if (preset) begin
            hist.delete();
            m_tsr = 3'b000;
        end else begin
            ev = 3'b000;
            if (hist.size() > 0) begin
                p = hist[hist.size()-1];
                if (!p.ld) begin
                    if (en && !updw && p.c == 8'd255 && cnt == 8'd0)   ev[0] = 1'b1;
                    if (en && updw  && p.c == 8'd0   && cnt == 8'd255) ev[1] = 1'b1;
`ifdef TIMER_STATUS_CMP_EN
                    if (cnt == tcmp && cnt != p.c) ev[2] = 1'b1;
`endif
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (ev[i]) m_tsr[i] = 1'b1;
                else if (tsr_wr && tsr_wdata[i]) m_tsr[i] = 1'b0;
            end
            m_tsr = m_tsr & IMPL;
            hist.push_back('{cnt, load});
            if (hist.size() > 2) void'(hist.pop_front());
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge pclk) begin
        if (check_on) begin
            vectors++;
            if (tsr !== m_tsr || irq !== |(m_tsr & tier)) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t tsr=%b irq=%b exp tsr=%b irq=%b",
                         $time, tsr, irq, m_tsr, |(m_tsr & tier));
            end
        end
    end

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", nm, act, exp);
        end
    endtask

    logic       pend_load;
    logic [7:0] tdr;
    int         r;

    initial begin
        preset = 1'b1; cnt = 8'h00; updw = 1'b0; en = 1'b1; load = 1'b0;
        tsr_wr = 1'b0; tsr_wdata = 3'b000; tier = 3'b001; tcmp = 8'h40;
        cyc();
        cyc();
        check_on = 1'b1;
        chk("reset_tsr", {1'b0, tsr}, 4'b0000);
        chk("reset_irq", {3'b0, irq}, 4'b0000);
        preset = 1'b0;

        // Up-count overflow, flag exactly one cycle after cnt shows 00.
        cnt = 8'hFE; cyc();
        cnt = 8'hFF; cyc();
        cnt = 8'h00; #1;
        chk("ovf_not_early", {1'b0, tsr}, 4'b0000);
        cyc();
        chk("ovf_tsr", {1'b0, tsr}, 4'b0001);
        chk("ovf_irq", {3'b0, irq}, 4'b0001);
        cyc(); cyc();
        chk("ovf_hold_00", {1'b0, tsr}, 4'b0001);
        tsr_wr = 1'b1; tsr_wdata = 3'b001; cyc();
        tsr_wr = 1'b0;
        chk("ovf_clear", {irq, tsr}, 4'b0000);

        // Down-count underflow with the interrupt masked, then unmasked.
        updw = 1'b1; tier = 3'b000;
        cnt = 8'h01; cyc();
        cnt = 8'h00; cyc();
        cnt = 8'hFF; cyc();
        chk("udf_tsr", {1'b0, tsr}, 4'b0010);
        chk("udf_irq_masked", {3'b0, irq}, 4'b0000);
        tier = 3'b010; #1;
        chk("udf_irq_enabled", {3'b0, irq}, 4'b0001);
        tsr_wr = 1'b1; tsr_wdata = 3'b000; cyc();
        chk("write_zero_keeps", {1'b0, tsr}, 4'b0010);
        tsr_wdata = 3'b010; cyc();
        tsr_wr = 1'b0; tsr_wdata = 3'b000;
        chk("udf_clear", {irq, tsr}, 4'b0000);

        // Loading 00 over FF must not look like an overflow.
        updw = 1'b0; tier = 3'b001;
        load = 1'b1; cyc();
        load = 1'b0; cnt = 8'h00; cyc();
        cyc();
        chk("load_masks_wrap", {1'b0, tsr}, 4'b0000);

        // New overflow coinciding with a clear write: set wins.
        cnt = 8'hFF; cyc();
        cnt = 8'h00; cyc();
        chk("ovf2_set", {1'b0, tsr}, 4'b0001);
        cnt = 8'hFF; cyc();
        cnt = 8'h00; tsr_wr = 1'b1; tsr_wdata = 3'b001; cyc();
        chk("set_beats_clear", {1'b0, tsr}, 4'b0001);
        cyc();
        tsr_wr = 1'b0; tsr_wdata = 3'b000;
        chk("clear_after_set", {irq, tsr}, 4'b0000);

        // Non-adjacent jump FF->01 is not a wrap.
        cnt = 8'hFF; cyc();
        cnt = 8'h01; cyc(); cyc();
        chk("jump_no_wrap", {1'b0, tsr}, 4'b0000);

        // Reset with both flags set; counter parked at FF in down mode afterwards.
        cnt = 8'hFF; cyc();
        cnt = 8'h00; cyc();
        updw = 1'b1; cnt = 8'hFF; cyc();
        chk("pre_reset_tsr", {1'b0, tsr}, 4'b0011);
        preset = 1'b1; cyc();
        chk("mid_reset_tsr", {irq, tsr}, 4'b0000);
        preset = 1'b0; cyc(); cyc();
        chk("post_reset_no_udf", {1'b0, tsr}, 4'b0000);

        // Randomized counter traffic.
        pend_load = 1'b0; tdr = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            preset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) < 3) updw = ~updw;
            en = ($urandom_range(0, 99) < 90);
            r = $urandom_range(0, 99);
            if (pend_load)      cnt = tdr;
            else if (r < 2)     cnt = 8'($urandom);
            else if (r < 5)     cnt = updw ? 8'h02 : 8'hFD;
            else if (en)        cnt = updw ? cnt - 8'd1 : cnt + 8'd1;
            load = ($urandom_range(0, 99) < 4);
            pend_load = load;
            case ($urandom_range(0, 4))
                0: tdr = 8'h00;
                1: tdr = 8'hFF;
                2: tdr = 8'h01;
                3: tdr = 8'hFE;
                default: tdr = 8'($urandom);
            endcase
            tsr_wr    = ($urandom_range(0, 99) < 15);
            tsr_wdata = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 10) tier = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 2)  tcmp = 8'($urandom);
            cyc();
        end

        preset = 1'b0; load = 1'b0; tsr_wr = 1'b0;
        cyc(); cyc();
        check_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
